// File: rtl/scaler_stages_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaler_stages_pkg                                                    |
// | Shared scaler constants: stage count default and stage-name mapping. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package scaler_stages_pkg;

  localparam int c_nstages_default = 4;
  localparam int c_nstages_min     = 2;
  localparam int c_nstages_max     = 12;

  // FS_OUT bit 0 is scaler stage FS03; bit i is FS(03+i).
  localparam int c_first_stage_num = 3;

  function automatic int stage_name_num(input int bit_idx);
    return bit_idx + c_first_stage_num;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scaler_stages_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaler_stages_if                                                     |
// | Carry input, stage outputs and interrupt handshake of the scaler.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface scaler_stages_if
  import scaler_stages_pkg::*;
#(
  parameter int NSTAGES = c_nstages_default
);

  logic               FS02;
  logic [NSTAGES-1:0] FS_OUT;
  logic [NSTAGES-1:0] FA_OUT;
  logic [NSTAGES-1:0] FB_OUT;
  logic               RUPT_REQ;
  logic               RUPT_ACK;

  modport slave (
    input  FS02,
    input  RUPT_ACK,
    output FS_OUT,
    output FA_OUT,
    output FB_OUT,
    output RUPT_REQ
  );

  modport master (
    output FS02,
    output RUPT_ACK,
    input  FS_OUT,
    input  FA_OUT,
    input  FB_OUT,
    input  RUPT_REQ
  );

endinterface
`default_nettype wire

// File: rtl/scaler_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaler_bit                                                           |
// | One binary scaler stage: toggles on carry-in, emits A/B phase pulses.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module scaler_bit (
  input  wire logic FS01_,
  input  wire logic rst,
  input  wire logic i_carry,
  output logic      o_state,
  output logic      o_fa,
  output logic      o_fb,
  output logic      o_carry
);

  logic r_state;
  logic r_fa;
  logic r_fb;

  always_ff @(posedge FS01_ or posedge rst) begin
    if (rst) begin
      r_state <= 1'b0;
      r_fa    <= 1'b0;
      r_fb    <= 1'b0;
    end else if (i_carry) begin
      r_state <= ~r_state;
      r_fa    <= ~r_state;
      r_fb    <= r_state;
    end else begin
      r_fa    <= 1'b0;
      r_fb    <= 1'b0;
    end
  end

  // Ripple carry uses the pre-edge state so the whole chain increments in one edge.
  assign o_carry = i_carry & r_state;
  assign o_state = r_state;
  assign o_fa    = r_fa;
  assign o_fb    = r_fb;

endmodule
`default_nettype wire

// File: rtl/scaler_stages.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaler_stages                                                        |
// | FS03.. binary scaler chain clocked by FS02 falling edges, with       |
// | sticky wrap interrupt request.                                       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module scaler_stages
  import scaler_stages_pkg::*;
#(
  parameter int NSTAGES = c_nstages_default
) (
  input  wire logic      FS01_,
  input  wire logic      rst,
  scaler_stages_if.slave bus
);

  logic               r_fs02_q;
  logic               r_rupt_req;
  logic               w_carry;
  logic               w_wrap;
  logic [NSTAGES:0]   w_chain;
  logic [NSTAGES-1:0] w_state;
  logic [NSTAGES-1:0] w_fa;
  logic [NSTAGES-1:0] w_fb;

  always_ff @(posedge FS01_ or posedge rst) begin
    if (rst) begin
      r_fs02_q <= 1'b0;
    end else begin
      r_fs02_q <= bus.FS02;
    end
  end

  // Carry is seen on the first edge that samples FS02 low after it was high.
  assign w_carry    = r_fs02_q & ~bus.FS02;
  assign w_chain[0] = w_carry;

  generate
    for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
      scaler_bit u_bit (
        .FS01_   (FS01_),
        .rst     (rst),
        .i_carry (w_chain[gi]),
        .o_state (w_state[gi]),
        .o_fa    (w_fa[gi]),
        .o_fb    (w_fb[gi]),
        .o_carry (w_chain[gi+1])
      );
    end
  endgenerate

  assign w_wrap = w_chain[NSTAGES];

  // Wrap wins over a coincident acknowledge.
  always_ff @(posedge FS01_ or posedge rst) begin
    if (rst) begin
      r_rupt_req <= 1'b0;
    end else if (w_wrap) begin
      r_rupt_req <= 1'b1;
    end else if (bus.RUPT_ACK) begin
      r_rupt_req <= 1'b0;
    end
  end

  assign bus.FS_OUT   = w_state;
  assign bus.FA_OUT   = w_fa;
  assign bus.FB_OUT   = w_fb;
  assign bus.RUPT_REQ = r_rupt_req;

endmodule
`default_nettype wire

// File: tb/tb_scaler_stages.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scaler_stages                                                     |
// | Scoreboard bench: arithmetic counter model vs. scaler_stages.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_scaler_stages;
  import scaler_stages_pkg::*;

  localparam int  N    = 4;
  localparam time HALF = 4883;

  typedef struct {
    logic [N-1:0] fs;
    logic [N-1:0] fa;
    logic [N-1:0] fb;
    logic         req;
  } exp_t;

  logic FS01_ = 1'b0;
  logic rst;

  scaler_stages_if #(.NSTAGES(N)) bus ();

  scaler_stages #(.NSTAGES(N)) dut (
    .FS01_ (FS01_),
    .rst   (rst),
    .bus   (bus)
  );

  always #HALF FS01_ = ~FS01_;

  exp_t        sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  bit          m_q;
  int unsigned m_cnt;
  bit          m_req;

  task automatic chkv(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, want, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, want, $time);
    end
  endtask

  // Reference: FS_OUT is a plain modulo-2**N count of FS02 falling edges.
  function automatic exp_t model_step(input bit r, input bit fs02, input bit ack);
    exp_t        e;
    int unsigned old;
    e.fa = '0;
    e.fb = '0;
    if (r) begin
      m_q   = 1'b0;
      m_cnt = 0;
      m_req = 1'b0;
    end else begin
      if (m_q && !fs02) begin
        old   = m_cnt;
        m_cnt = (m_cnt + 1) % (1 << N);
        e.fa  = N'(m_cnt & ~old);
        e.fb  = N'(old & ~m_cnt);
        if (m_cnt == 0) m_req = 1'b1;
        else if (ack)   m_req = 1'b0;
      end else if (ack) begin
        m_req = 1'b0;
      end
      m_q = fs02;
    end
    e.fs  = N'(m_cnt);
    e.req = m_req;
    return e;
  endfunction

  task automatic drive_and_push(input bit r, input bit fs02, input bit ack);
    rst          = r;
    bus.FS02     = fs02;
    bus.RUPT_ACK = ack;
    sb_q.push_back(model_step(r, fs02, ack));
  endtask

  task automatic cycle(input bit r, input bit fs02, input bit ack);
    @(negedge FS01_);
    drive_and_push(r, fs02, ack);
  endtask

  task automatic fall_edge(input bit ack_at_edge);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, ack_at_edge);
  endtask

  task automatic after_edge();
    @(posedge FS01_);
    #1;
  endtask

  // Monitor: every rising edge presents a new output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge FS01_);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chkv("fs_out",   bus.FS_OUT,   e.fs);
        chkv("fa_out",   bus.FA_OUT,   e.fa);
        chkv("fb_out",   bus.FB_OUT,   e.fb);
        chkb("rupt_req", bus.RUPT_REQ, e.req);
        chkv("fa_fb_overlap", bus.FA_OUT & bus.FB_OUT, '0);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.FS02     = 1'b0;
    bus.RUPT_ACK = 1'b0;
    m_q   = 1'b0;
    m_cnt = 0;
    m_req = 1'b0;

    for (int i = 0; i < 5; i++) cycle(1'b1, 1'(i % 2 == 0), 1'(i % 2));
    after_edge();
    chkv("reset_fs", bus.FS_OUT, '0);
    chkb("reset_req", bus.RUPT_REQ, 1'b0);

    for (int k = 1; k <= 5; k++) begin
      fall_edge(1'b0);
      if (k == 4) begin
        after_edge();
        chkv("edge4_fa", bus.FA_OUT, 4'b0100);
        chkv("edge4_fb", bus.FB_OUT, 4'b0011);
      end
    end
    after_edge();
    chkv("edge5_fs", bus.FS_OUT, 4'b0101);

    for (int k = 6; k <= 16; k++) fall_edge(1'b0);
    after_edge();
    chkv("wrap16_fs", bus.FS_OUT, 4'b0000);
    chkv("wrap16_fb", bus.FB_OUT, 4'b1111);
    chkb("wrap16_req", bus.RUPT_REQ, 1'b1);

    cycle(1'b0, 1'b1, 1'b1);
    after_edge();
    chkb("ack_clears_req", bus.RUPT_REQ, 1'b0);

    for (int k = 17; k <= 31; k++) fall_edge(1'b0);
    fall_edge(1'b1);
    after_edge();
    chkb("wrap32_ack_req", bus.RUPT_REQ, 1'b1);
    chkv("wrap32_fs", bus.FS_OUT, 4'b0000);

    for (int k = 1; k <= 11; k++) fall_edge(1'b0);
    after_edge();
    chkv("pre_reset_fs", bus.FS_OUT, 4'b1011);

    @(negedge FS01_);
    #100;
    rst = 1'b1;
    void'(model_step(1'b1, 1'b0, 1'b0));
    #1;
    chkv("async_rst_fs", bus.FS_OUT, '0);
    chkb("async_rst_req", bus.RUPT_REQ, 1'b0);
    #999;
    drive_and_push(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    after_edge();
    chkv("post_reset_fs", bus.FS_OUT, 4'b0001);

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0);
    after_edge();
    chkv("static_fs", bus.FS_OUT, '0);
    chkv("static_fa", bus.FA_OUT, '0);
    chkv("static_fb", bus.FB_OUT, '0);

    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0));
    end
    cycle(1'b0, 1'b1, 1'b0);

    repeat (2) @(posedge FS01_);
    #2;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never observed", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scaler_stages.md
SCALER_STAGES -- requirements
Module: scaler_stages

Interface
REQ-001 SHALL have parameter NSTAGES, default 4, giving the number of binary scaler stages after FS02 (stages FS03..FS(02+NSTAGES)); legal range 2..12.
REQ-002 SHALL have port FS01_  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port FS02  input  1  stage-02 scaler output from the upstream divider; carry source.
REQ-005 SHALL have port FS_OUT  output  NSTAGES  scaler stage states; bit 0 = FS03, bit NSTAGES-1 = FS(02+NSTAGES).
REQ-006 SHALL have port FA_OUT  output  NSTAGES  per-stage "A" phase pulse; bit i high one cycle when FS_OUT[i] goes 0->1.
REQ-007 SHALL have port FB_OUT  output  NSTAGES  per-stage "B" phase pulse; bit i high one cycle when FS_OUT[i] goes 1->0.
REQ-008 SHALL have port RUPT_REQ  output  1  sticky overflow request, set when the whole chain wraps.
REQ-009 SHALL have port RUPT_ACK  input  1  clears RUPT_REQ.

Function
REQ-010 SHALL register FS02 on every FS01_ rising edge into FS02_q; a carry is the condition FS02_q=1 and FS02=0 at that edge (FS02 falling edge).
REQ-011 SHALL treat FS_OUT as an NSTAGES-bit up counter incremented by exactly 1 at each edge where a carry is detected; no change otherwise.
REQ-012 SHALL update FS_OUT at the same FS01_ edge at which the carry is detected (zero-cycle latency from the first sample of FS02=0).
REQ-013 SHALL wrap FS_OUT from all-ones to zero modulo 2**NSTAGES without saturation.
REQ-014 SHALL register FA_OUT/FB_OUT at the same edge FS_OUT updates, so each pulse is high exactly one FS01_ cycle, aligned with the new FS_OUT value.
REQ-015 SHALL drive FA_OUT and FB_OUT to all-zero in any cycle with no carry.
REQ-016 SHALL never assert FA_OUT[i] and FB_OUT[i] together.
REQ-017 SHALL set RUPT_REQ at the edge where FS_OUT wraps all-ones->zero.
REQ-018 SHALL clear RUPT_REQ at an edge where RUPT_ACK=1 and no wrap occurs; ACK while RUPT_REQ=0 has no effect.
REQ-019 SHALL give set priority: wrap and RUPT_ACK at the same edge leaves RUPT_REQ=1.
REQ-020 SHALL hold RUPT_REQ indefinitely without ACK; further wraps do not generate additional state.
REQ-021 SHALL not detect a carry if FS02 is constant, including FS02=1 held through and after reset release.

Reset
REQ-022 SHALL on rst=1 force, asynchronously, FS02_q=0, FS_OUT=0, FA_OUT=0, FB_OUT=0, RUPT_REQ=0.
REQ-023 SHALL hold all outputs at reset values while rst=1 regardless of FS02 or RUPT_ACK.
REQ-024 SHALL, on reset asserted mid-count, discard count and pending RUPT_REQ; first carry after release counts from 0.
REQ-025 SHALL, because FS02_q resets to 0, not create a carry on the first edge after release even if FS02=1.

Structure
REQ-026 SHALL place NSTAGES default and the stage-index-to-name mapping (bit 0 = FS03) in the shared scaler package used by the upstream divider stage.
REQ-027 SHALL use one sub-module, scaler_bit, instantiated NSTAGES times: inputs carry-in, outputs state, A pulse, B pulse, carry-out (carry-out = carry-in and state=1).
REQ-028 SHALL keep the RUPT_REQ logic and FS02 edge detector in the top level.

Verification
REQ-029 SHALL cover reset: rst=1 with FS02 toggling for 5 cycles -> FS_OUT=0, FA/FB=0, RUPT_REQ=0 throughout.
REQ-030 SHALL cover counting: FS01_ period 9.766 us, upstream divide-by-2 FS02; after 5 FS02 falling edges -> FS_OUT=4'b0101; at the 4th edge FA_OUT=4'b0100 and FB_OUT=4'b0011 for one cycle.
REQ-031 SHALL cover wrap: 16 FS02 falling edges -> FS_OUT=0, FB_OUT=4'b1111 one cycle, RUPT_REQ=1 from that edge.
REQ-032 SHALL cover handshake: RUPT_ACK=1 one cycle after wrap -> RUPT_REQ=0 next edge; RUPT_ACK=1 coincident with 32nd edge wrap -> RUPT_REQ stays 1.
REQ-033 SHALL cover mid-count reset: rst pulsed 1 us at FS_OUT=4'b1011 with RUPT_REQ=1 -> immediate FS_OUT=0, RUPT_REQ=0; next carry -> FS_OUT=4'b0001.
REQ-034 SHALL cover static input: FS02 held 1 across reset release for 20 cycles -> FS_OUT=0, no pulses.
